// File: rtl/dispatcher_rr.sv
`default_nettype none
// ============================================================================
// Module      : dispatcher_rr
// Description : Round-robin dispatcher. Each accepted input datum is steered
//               to the first output, starting from a rotating pointer, whose
//               2-entry FIFO has room. Every output drives its FIFO head.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : DWIDTH - data width in bits
//               N      - number of output streams (N >= 1)
// Ports       : clk        - clock, all state on rising edge
//               rst        - synchronous active-high reset
//               in_valid   - upstream datum valid
//               in_data    - upstream datum
//               in_ready   - dispatcher accepts in_data this cycle
//               out_valid  - [N] output i holds a datum
//               out_data   - [N] head datum of output i
//               out_ready  - [N] consumer i accepts
//               busy       - at least one output FIFO is non-empty
// ============================================================================
module dispatcher_rr #(
  parameter int DWIDTH = 8,
  parameter int N      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid [N-1:0],
  output logic [DWIDTH-1:0] out_data  [N-1:0],
  input  logic              out_ready [N-1:0],
  output logic              busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] sel;
  logic [N-1:0]  notfull;
  logic [N-1:0]  nonempty;
  logic          in_fire;

  // in_ready looks only at registered FIFO counts (and rst), never at
  // in_valid or out_ready, so a pop in this cycle does not free a slot
  // for this cycle's push.
  assign in_ready = !rst && (|notfull);
  assign busy     = |nonempty;
  assign in_fire  = in_valid && in_ready;

  // Scan ptr, ptr+1, ... wrapping, for the first FIFO with room.
  always_comb begin : p_sel
    logic [PW:0] idx;
    logic        found;
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(N)) begin
        idx = idx - (PW+1)'(N);
      end
      if (!found && notfull[idx[PW-1:0]]) begin
        sel   = idx[PW-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (in_fire) begin
      ptr_d = (sel == PW'(N - 1)) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_fifo
    logic [1:0]        cnt_q;
    logic [1:0]        cnt_d;
    logic [DWIDTH-1:0] m0_q;   // head entry
    logic [DWIDTH-1:0] m1_q;   // second entry
    logic [DWIDTH-1:0] m0_d;
    logic [DWIDTH-1:0] m1_d;
    logic              push;
    logic              pop;

    assign notfull[i]   = (cnt_q != 2'd2);
    assign nonempty[i]  = (cnt_q != 2'd0);
    assign out_valid[i] = nonempty[i];
    assign out_data[i]  = m0_q;

    assign push = in_fire && (sel == PW'(i));
    assign pop  = nonempty[i] && out_ready[i];

    always_comb begin
      cnt_d = cnt_q;
      m0_d  = m0_q;
      m1_d  = m1_q;
      case ({push, pop})
        2'b10: begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd0) begin
            m0_d = in_data;
          end else begin
            m1_d = in_data;
          end
        end
        2'b01: begin
          cnt_d = cnt_q - 2'd1;
          m0_d  = m1_q;
        end
        2'b11: begin
          // Push only targets a non-full FIFO and pop needs a non-empty one,
          // so the count here is 1: the new datum becomes the sole entry.
          if (cnt_q == 2'd1) begin
            m0_d = in_data;
          end else begin
            m0_d = m1_q;
            m1_d = in_data;
          end
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= 2'd0;
        m0_q  <= '0;
        m1_q  <= '0;
      end else begin
        cnt_q <= cnt_d;
        m0_q  <= m0_d;
        m1_q  <= m1_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dispatcher_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_dispatcher_rr
// Description : Directed checks of dispatcher_rr with N=2 and N=3 instances,
//               plus a randomly stalled N=4 run against a per-output queue
//               model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dispatcher_rr;

  logic clk;
  logic rst;

  // N=2 instance
  logic       a_in_valid;
  logic [7:0] a_in_data;
  logic       a_in_ready;
  logic       a_out_valid [1:0];
  logic [7:0] a_out_data  [1:0];
  logic       a_out_ready [1:0];
  logic       a_busy;

  // N=3 instance
  logic       b_in_valid;
  logic [7:0] b_in_data;
  logic       b_in_ready;
  logic       b_out_valid [2:0];
  logic [7:0] b_out_data  [2:0];
  logic       b_out_ready [2:0];
  logic       b_busy;

  // N=4 instance
  logic       c_in_valid;
  logic [7:0] c_in_data;
  logic       c_in_ready;
  logic       c_out_valid [3:0];
  logic [7:0] c_out_data  [3:0];
  logic       c_out_ready [3:0];
  logic       c_busy;

  int checks = 0;
  int errors = 0;

  dispatcher_rr #(.DWIDTH(8), .N(2)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_ready(a_out_ready), .busy(a_busy));

  dispatcher_rr #(.DWIDTH(8), .N(3)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_ready(b_out_ready), .busy(b_busy));

  dispatcher_rr #(.DWIDTH(8), .N(4)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_data(c_in_data),
    .in_ready(c_in_ready), .out_valid(c_out_valid), .out_data(c_out_data),
    .out_ready(c_out_ready), .busy(c_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse; in_ready of every instance must be low while rst is high.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    check("rst_inrdy_a", a_in_ready, 0);
    check("rst_inrdy_b", b_in_ready, 0);
    rst = 1'b0;
    #1;
  endtask

  // Random-run model state
  logic [7:0] q [4][$];
  int         m_ptr = 0;
  int         sent  = 0;
  int         recv  = 0;
  logic [7:0] nxt   = 8'h00;

  task automatic rnd_cycle();
    bit m_rdy;
    int sel;
    m_rdy = 1'b0;
    sel   = -1;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_ptr + k) % 4;
      if (q[idx].size() < 2) begin
        m_rdy = 1'b1;
        if (sel < 0) sel = idx;
      end
    end
    check("rnd_inrdy", c_in_ready, m_rdy);
    for (int i = 0; i < 4; i++) begin
      check("rnd_valid", c_out_valid[i], q[i].size() != 0);
      if (q[i].size() != 0) begin
        check("rnd_data", c_out_data[i], q[i][0]);
        if (c_out_ready[i]) begin
          void'(q[i].pop_front());
          recv++;
        end
      end
    end
    if (c_in_valid && m_rdy) begin
      q[sel].push_back(c_in_data);
      m_ptr = (sel + 1) % 4;
      sent++;
      nxt++;
    end
    tick();
  endtask

  initial begin
    rst = 1'b0;
    a_in_valid = 0; a_in_data = 0; a_out_ready[0] = 0; a_out_ready[1] = 0;
    b_in_valid = 0; b_in_data = 0;
    for (int i = 0; i < 3; i++) b_out_ready[i] = 0;
    c_in_valid = 0; c_in_data = 0;
    for (int i = 0; i < 4; i++) c_out_ready[i] = 0;
    tick();

    // ---- reset state ----
    do_reset();
    check("rst_v0", a_out_valid[0], 0);
    check("rst_v1", a_out_valid[1], 0);
    check("rst_d0", a_out_data[0], 0);
    check("rst_busy", a_busy, 0);
    check("rst_inrdy_rel", a_in_ready, 1);

    // ---- back-to-back, all ready ----
    a_out_ready[0] = 1; a_out_ready[1] = 1;
    a_in_valid = 1; a_in_data = 8'h11;
    tick();
    check("b2b_v0_11", a_out_valid[0], 1);
    check("b2b_d0_11", a_out_data[0], 8'h11);
    check("b2b_v1_11", a_out_valid[1], 0);
    check("b2b_inrdy1", a_in_ready, 1);
    a_in_data = 8'h22;
    tick();
    check("b2b_v0_22", a_out_valid[0], 0);
    check("b2b_d1_22", a_out_data[1], 8'h22);
    check("b2b_inrdy2", a_in_ready, 1);
    a_in_data = 8'h33;
    tick();
    check("b2b_d0_33", a_out_data[0], 8'h33);
    check("b2b_v0_33", a_out_valid[0], 1);
    check("b2b_v1_33", a_out_valid[1], 0);
    a_in_data = 8'h44;
    tick();
    check("b2b_d1_44", a_out_data[1], 8'h44);
    check("b2b_v1_44", a_out_valid[1], 1);
    check("b2b_inrdy3", a_in_ready, 1);
    a_in_valid = 0;
    tick();
    check("b2b_busy_end", a_busy, 0);

    // ---- fill with no consumers ----
    do_reset();
    a_out_ready[0] = 0; a_out_ready[1] = 0;
    a_in_valid = 1;
    for (int k = 0; k < 4; k++) begin
      a_in_data = 8'hA0 + 8'(k);
      check("fill_inrdy", a_in_ready, 1);
      tick();
    end
    a_in_data = 8'hA4;
    check("fill_full_inrdy", a_in_ready, 0);
    tick();
    check("fill_hold_inrdy", a_in_ready, 0);
    check("fill_d0", a_out_data[0], 8'hA0);
    check("fill_d1", a_out_data[1], 8'hA1);
    check("fill_busy", a_busy, 1);
    a_out_ready[1] = 1;
    tick();
    a_out_ready[1] = 0;
    check("fill_pop_d1", a_out_data[1], 8'hA3);
    check("fill_pop_inrdy", a_in_ready, 1);
    tick();
    check("fill_a4_inrdy", a_in_ready, 0);
    check("fill_d0_stable", a_out_data[0], 8'hA0);
    a_in_valid = 0;
    a_out_ready[1] = 1;
    tick();
    a_out_ready[1] = 0;
    check("fill_a4_out1", a_out_data[1], 8'hA4);

    // ---- simultaneous push/pop on one FIFO ----
    do_reset();
    a_in_valid = 1; a_in_data = 8'hB1;
    tick();
    a_in_data = 8'hB2;
    tick();
    a_out_ready[0] = 1; a_in_data = 8'hB3;
    tick();
    a_in_valid = 0;
    check("pp_v0", a_out_valid[0], 1);
    check("pp_d0", a_out_data[0], 8'hB3);
    tick();
    check("pp_cnt1", a_out_valid[0], 0);
    check("pp_d1", a_out_data[1], 8'hB2);
    a_out_ready[0] = 0;

    // ---- reset mid-operation ----
    do_reset();
    a_in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      a_in_data = 8'hC0 + 8'(k);
      tick();
    end
    rst = 1; a_in_data = 8'hDD;
    #1;
    check("mid_rst_inrdy", a_in_ready, 0);
    tick();
    rst = 0; a_in_valid = 0;
    #1;
    check("mid_rst_v0", a_out_valid[0], 0);
    check("mid_rst_v1", a_out_valid[1], 0);
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_d1", a_out_data[1], 0);
    a_in_valid = 1; a_in_data = 8'h5A;
    tick();
    a_in_valid = 0;
    check("post_rst_v0", a_out_valid[0], 1);
    check("post_rst_d0", a_out_data[0], 8'h5A);
    check("post_rst_v1", a_out_valid[1], 0);

    // ---- N=3 skip of a full output ----
    b_out_ready[0] = 1; b_out_ready[2] = 1; b_out_ready[1] = 0;
    b_in_valid = 1;
    for (int k = 0; k < 7; k++) begin
      b_in_data = 8'hE0 + 8'(k);
      check("skip_setup_inrdy", b_in_ready, 1);
      tick();
    end
    b_in_data = 8'h01;
    tick();
    check("skip_01_v2", b_out_valid[2], 1);
    check("skip_01_d2", b_out_data[2], 8'h01);
    check("skip_01_v0", b_out_valid[0], 0);
    b_in_data = 8'h02;
    tick();
    check("skip_02_v0", b_out_valid[0], 1);
    check("skip_02_d0", b_out_data[0], 8'h02);
    check("skip_02_v2", b_out_valid[2], 0);
    b_in_data = 8'h03;
    tick();
    check("skip_03_d2", b_out_data[2], 8'h03);
    check("skip_03_v0", b_out_valid[0], 0);
    b_in_data = 8'h04;
    tick();
    b_in_valid = 0;
    check("skip_ptr0_v0", b_out_valid[0], 1);
    check("skip_ptr0_d0", b_out_data[0], 8'h04);
    check("skip_out1_head", b_out_data[1], 8'hE1);

    // ---- N=4 random stall ----
    do_reset();
    for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
      c_in_valid = ($urandom_range(0, 3) != 0);
      c_in_data  = nxt;
      for (int i = 0; i < 4; i++) c_out_ready[i] = 1'($urandom_range(0, 1));
      rnd_cycle();
    end
    check("rnd_sent", sent, 1000);
    c_in_valid = 0;
    for (int i = 0; i < 4; i++) c_out_ready[i] = 1;
    for (int k = 0; k < 4; k++) rnd_cycle();
    check("rnd_recv", recv, 1000);
    check("rnd_busy_end", c_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dispatcher_rr.md
DISPATCHER_RR -- requirements
Module: dispatcher_rr

Interface
REQ-001 The module SHALL have parameter DWIDTH, default 8, giving the data width in bits.
REQ-002 The module SHALL have parameter N, default 2, giving the number of output streams (N >= 1; a power of two is not required).
REQ-003 The module SHALL have clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have in_valid, input, 1 bit: the upstream datum is valid.
REQ-006 The module SHALL have in_data, input, DWIDTH bits: the upstream datum.
REQ-007 The module SHALL have in_ready, output, 1 bit: the dispatcher accepts in_data this cycle.
REQ-008 The module SHALL have out_valid, output, unpacked array [N-1:0] of 1 bit: output i holds a valid datum.
REQ-009 The module SHALL have out_data, output, unpacked array [N-1:0] of DWIDTH bits: the head datum of output i.
REQ-010 The module SHALL have out_ready, input, unpacked array [N-1:0] of 1 bit: the downstream consumer i accepts.
REQ-011 The module SHALL have busy, output, 1 bit: at least one output buffer is non-empty.

Function
REQ-012 Each output i SHALL own a 2-entry FIFO (count 0..2); out_valid[i] = (count_i != 0) and out_data[i] = FIFO head, both driven from registers.
REQ-013 A transfer SHALL occur on the input when in_valid & in_ready, and on output i when out_valid[i] & out_ready[i].
REQ-014 in_ready SHALL be 1 if and only if rst = 0 and at least one FIFO has count < 2; in_ready SHALL depend only on registered state, with no combinational path from in_valid or out_ready.
REQ-015 The target output SHALL be sel = the first index found scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 whose count < 2.
REQ-016 On an input transfer, in_data SHALL be written to FIFO sel and ptr SHALL become sel+1, wrapping from N-1 to 0.
REQ-017 Without an input transfer, ptr SHALL hold its value; in_valid alone SHALL NOT move ptr.
REQ-018 For N = 1, ptr SHALL be constant 0.
REQ-019 Latency: a datum accepted at edge k into an empty FIFO SHALL appear on out_valid/out_data of that output after edge k (visible in cycle k+1); there is no same-cycle bypass.
REQ-020 Simultaneous push and pop on the same FIFO SHALL leave count unchanged and preserve FIFO order.
REQ-021 A push into a full FIFO SHALL never occur, by construction of REQ-014 and REQ-015.
REQ-022 A pop from an empty FIFO SHALL never occur, because out_valid = 0 when the FIFO is empty.
REQ-023 Each output stream SHALL preserve the input order of the data dispatched to it; data SHALL never be lost or duplicated.
REQ-024 busy SHALL be the registered-state OR of (count_i != 0) over all outputs.
REQ-025 While out_valid[i] = 1 and out_ready[i] = 0, out_data[i] SHALL remain stable.

Reset
REQ-026 When rst = 1 at a clock edge, all FIFO counts SHALL become 0, ptr SHALL become 0, and FIFO storage SHALL be cleared to 0.
REQ-027 After a reset edge, out_valid[i] = 0, out_data[i] = 0 and busy = 0.
REQ-028 in_ready SHALL be 0 while rst = 1.
REQ-029 Reset asserted mid-operation SHALL discard all buffered data; no out_valid SHALL be asserted in the cycle after the reset edge.
REQ-030 The first datum accepted after reset SHALL be dispatched to output 0.

Verification
REQ-031 Scenario, N=2, all out_ready=1: send 0x11, 0x22, 0x33, 0x44 back-to-back -> out0 gets 0x11 then 0x33, out1 gets 0x22 then 0x44, each one cycle after acceptance; in_ready stays 1 throughout.
REQ-032 Scenario, N=2, all out_ready=0: send 0xA0..0xA5 -> 0xA0..0xA3 are accepted, alternating between out0 and out1; then in_ready=0 with 0xA4 held; raising out_ready[1] for one cycle pops 0xA1, and 0xA4 goes to out1 on the next cycle.
REQ-033 Scenario, N=3, out_ready[1]=0 and out1 already full (2 entries): send 0x01, 0x02, 0x03 with ptr=1 -> out1 is skipped, data go to out2, out0, out2 in that order, and ptr ends at 0.
REQ-034 Scenario, N=2, out0 count=1, out_ready[0]=1 while a push targets out0 in the same cycle -> count_0 stays 1, the head is the new datum next cycle, and order is preserved.
REQ-035 Scenario: accept 3 data, then assert rst for 1 cycle with in_valid=1 -> in_ready=0 during reset, then all out_valid=0 and busy=0; the next datum 0x5A goes to out0.
REQ-036 Scenario, random stall on all out_ready, N=4, 1000 data -> per-output scoreboard shows no loss, duplication or reordering, and no push into a full FIFO.
